// File: rtl/tty_tx_fifo.sv
// tty_tx_fifo
//   Serial transmitter for the PDP-8/e console / auxiliary teletype ports,
//   with a one-deep holding register in front of the shifter. Software can
//   load the next character while the current frame shifts out. The TTO flag
//   follows PDP-8 semantics: it is high when the holding register can accept
//   a character.
//
// Ports
//   clk100      system clock, all state changes on its rising edge
//   reset_n     asynchronous active-low reset
//   clear       synchronous initialise (CAF), same effect as reset
//   char[0:11]  AC value, bit 11 is the LSB
//   load        strobe: write char into the holding register (dropped if full)
//   clear_flag  strobe: clear flag
//   set_flag    strobe: set flag
//   flag        holding register empty / can take a character
//   busy        holding register full or a frame in progress
//   tx          registered serial line, idle (mark) level 1
module tty_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 2,
    parameter int BAUD_DIV  = 10417
) (
    input  logic        clk100,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [0:11] char,
    input  logic        load,
    input  logic        clear_flag,
    input  logic        set_flag,
    output logic        flag,
    output logic        busy,
    output logic        tx
);

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST      = CW'(BAUD_DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 r_state, w_state_nx;
    logic [CW-1:0]          r_cnt, w_cnt_nx;
    logic [2:0]             r_bit, w_bit_nx;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nx;
    logic                   r_par, w_par_nx;
    logic [DATA_BITS-1:0]   r_hold, w_hold_nx;
    logic                   r_hold_full, w_hold_full_nx;
    logic                   r_flag, w_flag_nx;
    logic                   r_tx, w_tx_nx;
    logic                   r_busy, w_busy_nx;
    logic                   w_xfer;
    logic                   w_bit_end;
    logic                   w_accept;

    // Upper AC bits are unused for narrow frames.
    logic w_unused_char;
    assign w_unused_char = ^char;

    assign flag = r_flag;
    assign busy = r_busy;
    assign tx   = r_tx;

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = '0;
        w_bit_nx       = r_bit;
        w_shift_nx     = r_shift;
        w_par_nx       = r_par;
        w_hold_nx      = r_hold;
        w_hold_full_nx = r_hold_full;
        w_tx_nx        = r_tx;
        w_xfer         = 1'b0;
        w_bit_end      = (r_cnt == LAST);
        w_accept       = load && !r_hold_full;

        if (r_state != ST_IDLE) begin
            w_cnt_nx = w_bit_end ? '0 : r_cnt + 1'b1;
        end

        // tx is registered, so it is loaded with the level of the bit being
        // entered on the same edge as the state change.
        case (r_state)
            ST_IDLE: begin
                w_tx_nx = 1'b1;
                if (r_hold_full) begin
                    w_state_nx = ST_START;
                    w_xfer     = 1'b1;
                    w_tx_nx    = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nx = ST_DATA;
                    w_bit_nx   = '0;
                    w_tx_nx    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == DATA_LAST) begin
                        w_bit_nx = '0;
                        if (PARITY != 0) begin
                            w_state_nx = ST_PARITY;
                            w_tx_nx    = r_par;
                        end else begin
                            w_state_nx = ST_STOP;
                            w_tx_nx    = 1'b1;
                        end
                    end else begin
                        w_bit_nx   = r_bit + 3'd1;
                        w_shift_nx = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_nx    = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nx = ST_STOP;
                    w_bit_nx   = '0;
                    w_tx_nx    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_bit == STOP_LAST) begin
                        w_bit_nx = '0;
                        if (r_hold_full) begin
                            w_state_nx = ST_START;
                            w_xfer     = 1'b1;
                            w_tx_nx    = 1'b0;
                        end else begin
                            w_state_nx = ST_IDLE;
                            w_tx_nx    = 1'b1;
                        end
                    end else begin
                        w_bit_nx = r_bit + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_tx_nx    = 1'b1;
            end
        endcase

        if (w_xfer) begin
            w_shift_nx     = r_hold;
            w_par_nx       = (^r_hold) ^ ODD;
            w_hold_full_nx = 1'b0;
        end

        // Transfer needs hold_full=1 and accept needs hold_full=0, so these
        // never fight over the holding register.
        if (w_accept) begin
            w_hold_nx      = char[12-DATA_BITS:11];
            w_hold_full_nx = 1'b1;
        end

        w_flag_nx = r_flag;
        if (w_xfer || set_flag) begin
            w_flag_nx = 1'b1;
        end else if (w_accept || clear_flag) begin
            w_flag_nx = 1'b0;
        end

        w_busy_nx = (w_state_nx != ST_IDLE) || w_hold_full_nx;
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_flag      <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else if (clear) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_flag      <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_bit       <= w_bit_nx;
            r_shift     <= w_shift_nx;
            r_par       <= w_par_nx;
            r_hold      <= w_hold_nx;
            r_hold_full <= w_hold_full_nx;
            r_flag      <= w_flag_nx;
            r_tx        <= w_tx_nx;
            r_busy      <= w_busy_nx;
        end
    end

endmodule

// File: tb/tb_tty_tx_fifo.sv
// tb_tty_tx_fifo
//   Scoreboard bench for tty_tx_fifo. Instance A is 8N2, instance B is 7E1,
//   both with 16 clocks per bit. Accepted loads push the expected frame (as a
//   string of line levels, first bit first) into a per-instance queue; a
//   monitor per instance waits for a start bit, pops, and checks every cycle
//   of every bit against the expected level.
module tb_tty_tx_fifo;

    localparam int BD = 16;

    typedef struct {
        string name;
        string bits;
        bit    b2b;
    } frame_t;

    logic        clk100;
    logic        reset_n;
    logic        clr_a, ld_a, cf_a, sf_a;
    logic [0:11] char_a;
    logic        flag_a, busy_a, tx_a;
    logic        clr_b, ld_b, cf_b, sf_b;
    logic [0:11] char_b;
    logic        flag_b, busy_b, tx_b;

    tty_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .BAUD_DIV(BD)) u_a (
        .clk100(clk100), .reset_n(reset_n), .clear(clr_a), .char(char_a),
        .load(ld_a), .clear_flag(cf_a), .set_flag(sf_a),
        .flag(flag_a), .busy(busy_a), .tx(tx_a)
    );

    tty_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .BAUD_DIV(BD)) u_b (
        .clk100(clk100), .reset_n(reset_n), .clear(clr_b), .char(char_b),
        .load(ld_b), .clear_flag(cf_b), .set_flag(sf_b),
        .flag(flag_b), .busy(busy_b), .tx(tx_b)
    );

    int     n_assert = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    frame_t q_a[$];
    frame_t q_b[$];
    logic   txv[2];
    bit     abort_v[2];

    assign txv[0] = tx_a;
    assign txv[1] = tx_b;

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;
    always @(posedge clk100) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, required completion earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input int act, input int req);
        n_assert++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic void expect_frame(input int id, input string name,
                                         input string bits, input bit b2b);
        frame_t f;
        f.name = name;
        f.bits = bits;
        f.b2b  = b2b;
        if (id == 0) q_a.push_back(f);
        else         q_b.push_back(f);
    endfunction

    function automatic int qsize(input int id);
        return (id == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic frame_t qpop(input int id);
        if (id == 0) return q_a.pop_front();
        return q_b.pop_front();
    endfunction

    task automatic run_monitor(input int id);
        frame_t e;
        int     start;
        int     prev_end = -100;
        int     errs;
        bit     aborted;
        bit     want;
        forever begin
            @(negedge clk100);
            abort_v[id] = 1'b0;
            if (txv[id] == 1'b0) begin
                start = cyc;
                if (qsize(id) == 0) begin
                    check($sformatf("unexpected frame on dut%0d at cycle", id), start, -1);
                end else begin
                    e = qpop(id);
                    if (e.b2b) check({e.name, " start cycle"}, start, prev_end + 1);
                    errs    = 0;
                    aborted = 1'b0;
                    for (int c = 0; c < e.bits.len() * BD; c++) begin
                        if (c != 0) @(negedge clk100);
                        if (abort_v[id]) begin
                            aborted     = 1'b1;
                            abort_v[id] = 1'b0;
                            break;
                        end
                        want = (e.bits[c / BD] == "1");
                        if (txv[id] !== want) errs++;
                        if ((c % BD) == BD - 1) begin
                            check($sformatf("%s bit%0d wrong-level cycles", e.name, c / BD), errs, 0);
                            errs = 0;
                        end
                    end
                    if (!aborted) prev_end = cyc;
                end
            end
        end
    endtask

    initial run_monitor(0);
    initial run_monitor(1);

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic load_a(input logic [11:0] c);
        char_a = c;
        ld_a   = 1'b1;
        tick();
        ld_a   = 1'b0;
    endtask

    task automatic pulse_a(input bit s, input bit cl);
        sf_a = s;
        cf_a = cl;
        tick();
        sf_a = 1'b0;
        cf_a = 1'b0;
    endtask

    task automatic wait_idle_a(input string name, input int t0, input int len);
        for (int i = 0; i < 600 && busy_a; i++) tick();
        check({name, " busy fall cycles after transfer"}, cyc - t0, len);
    endtask

    int t0;

    initial begin
        reset_n = 1'b0;
        {clr_a, ld_a, cf_a, sf_a} = '0;
        {clr_b, ld_b, cf_b, sf_b} = '0;
        char_a = '0;
        char_b = '0;
        repeat (3) tick();
        check("reset tx_a", tx_a, 1);
        check("reset flag_a", flag_a, 0);
        check("reset busy_a", busy_a, 0);
        check("reset tx_b", tx_b, 1);
        reset_n = 1'b1;
        repeat (2) tick();

        // single 8N2 frame, 12'o0101 -> data 0x41
        expect_frame(0, "single_0101", "01000001011", 1'b0);
        load_a(12'o0101);
        check("load edge busy", busy_a, 1);
        check("load edge flag", flag_a, 0);
        check("load edge tx", tx_a, 1);
        tick();
        t0 = cyc;
        check("transfer edge flag", flag_a, 1);
        check("transfer edge tx", tx_a, 0);
        wait_idle_a("single", t0, 176);
        repeat (5) tick();

        // back-to-back, overrun and flag priority
        expect_frame(0, "b2b_first_0101", "01000001011", 1'b0);
        expect_frame(0, "b2b_second_0102", "00100001011", 1'b1);
        load_a(12'o0101);
        tick();
        t0 = cyc;
        check("b2b transfer flag", flag_a, 1);
        load_a(12'o0102);
        check("second load clears flag", flag_a, 0);
        pulse_a(1'b1, 1'b0);
        check("set_flag while full", flag_a, 1);
        load_a(12'o0177);
        check("dropped load keeps flag", flag_a, 1);
        pulse_a(1'b0, 1'b1);
        check("clear_flag", flag_a, 0);
        pulse_a(1'b1, 1'b1);
        check("set and clear same edge", flag_a, 1);
        pulse_a(1'b0, 1'b1);
        check("clear_flag again", flag_a, 0);
        for (int i = 0; i < 300 && !flag_a; i++) tick();
        check("flag re-rise cycle", cyc - t0, 176);
        check("second start tx", tx_a, 0);
        t0 = cyc;
        wait_idle_a("b2b second", t0, 176);
        repeat (5) tick();

        // clear in the middle of data bit 2 (level 0 for 0x42)
        expect_frame(0, "aborted_0102", "00100001011", 1'b0);
        load_a(12'o0102);
        tick();
        t0 = cyc;
        while (cyc < t0 + 50) tick();
        check("pre-clear tx", tx_a, 0);
        abort_v[0] = 1'b1;
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("after clear tx", tx_a, 1);
        check("after clear busy", busy_a, 0);
        check("after clear flag", flag_a, 0);
        repeat (3) tick();
        expect_frame(0, "after_clear_0101", "01000001011", 1'b0);
        load_a(12'o0101);
        tick();
        t0 = cyc;
        wait_idle_a("after clear", t0, 176);

        // 7E1 on instance B: 12'o0103 -> 1000011b, even parity 1
        expect_frame(1, "7e1_0103", "0110000111", 1'b0);
        char_b = 12'o0103;
        ld_b   = 1'b1;
        tick();
        ld_b   = 1'b0;
        tick();
        t0 = cyc;
        check("7e1 transfer flag", flag_b, 1);
        for (int i = 0; i < 400 && busy_b; i++) tick();
        check("7e1 frame length", cyc - t0, 160);
        repeat (5) tick();

        // asynchronous reset mid-frame (cycle 40 = data bit 1, level 0)
        expect_frame(0, "reset_abort_0101", "01000001011", 1'b0);
        load_a(12'o0101);
        tick();
        t0 = cyc;
        while (cyc < t0 + 40) tick();
        check("pre-reset tx", tx_a, 0);
        #2;
        abort_v[0] = 1'b1;
        reset_n = 1'b0;
        #1;
        check("async reset tx", tx_a, 1);
        check("async reset flag", flag_a, 0);
        check("async reset busy", busy_a, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (20) tick();

        check("leftover expected frames a", q_a.size(), 0);
        check("leftover expected frames b", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tty_tx_fifo.md
# tty_tx_fifo

Parametrised serial transmitter for the PDP-8/e console and auxiliary teletype ports. It adds to the existing console transmitter a one-deep holding register, so software can load the next character while the current one shifts out. Data width, parity, stop bits and bit period are set at build time. It sits between the IOT decode for the 603x/604x device codes and the FPGA `tx` pin, and keeps PDP-8 TTO flag semantics.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, legal 5..8.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 2: legal 1 or 2.
- `BAUD_DIV`, 10417: `clk100` cycles per bit, legal ≥ 2. Counter width is `$clog2(BAUD_DIV)`.

Ports:
- `clk100`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous initialise (CAF). Same effect as reset, applied on the next edge.
- `char`  in  [0:11]  AC value; bit 11 is the LSB.
- `load`  in  1  one-cycle strobe (TLS/TPC) that writes `char` into the holding register.
- `clear_flag`  in  1  one-cycle strobe (TCF) that clears `flag`.
- `set_flag`  in  1  one-cycle strobe (TFL) that sets `flag`.
- `flag`  out  1  TTO flag: high means the holding register is empty and can take a character.
- `busy`  out  1  high while the holding register is full or a frame is in progress.
- `tx`  out  1  registered serial line; idle/mark level is 1.

## Operation
- Reset values (from `reset_n` low, or `clear` high on an edge):
  - `tx`=1, `flag`=0, `busy`=0.
  - Holding register empty, state IDLE, bit counter 0.
- Holding register `hold`:
  - `load` with `hold` empty: captures `char[12-DATA_BITS:11]`, sets `hold_full`, clears `flag`.
  - `load` with `hold` full: ignored. The character is dropped and `flag` is unchanged.
- Transfer: when the FSM enters START with `hold_full`=1:
  - shifter takes `hold`;
  - `hold_full` goes to 0;
  - `flag` goes to 1.
- Flag priority within one edge:
  - `clear` wins over everything.
  - Any set source (transfer or `set_flag`) wins over any clear source (`load` or `clear_flag`).
  - `load` and transfer cannot coincide, because they need opposite `hold_full` values.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If `hold_full`, go to START and transfer on the same edge.
  - START: `tx`=0 for `BAUD_DIV` cycles, then DATA.
  - DATA: sends `DATA_BITS` bits LSB first (`char[11]` first), each for `BAUD_DIV` cycles. Then PARITY if `PARITY`≠0, else STOP.
  - PARITY: sends the XOR of the data bits for even parity, its inverse for odd, for `BAUD_DIV` cycles.
  - STOP: `tx`=1 for `STOP_BITS`×`BAUD_DIV` cycles. At the end, if `hold_full`, go straight to START with a transfer (no idle gap); otherwise go to IDLE.
- `busy` = (state≠IDLE) | `hold_full`.
- Reset or `clear` mid-frame abandons the frame. `tx` returns to 1 and no flag is set.

## Timing
- `load` sampled at edge k:
  - `hold_full`=1 after edge k.
  - If idle, the transfer happens at edge k+1: `tx`=0 and `flag`=1 after edge k+1.
- Every bit lasts exactly `BAUD_DIV` cycles. There is no cumulative drift.
- Frame length is (1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`) × `BAUD_DIV` cycles.
- Back-to-back frames: the last stop-bit cycle is followed directly by the first start-bit cycle.
- A second `load` is accepted any time after the transfer edge. The flag re-rises when that character transfers, at the start of its frame.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset defaults, `BAUD_DIV`=16, 8N2: assert `reset_n`=0 mid-frame → `tx`=1, `flag`=0, `busy`=0 immediately, with no clock edge needed.
- Single frame, 8N2: `load` with `char`=12'o0101 → `tx` sequence 0,1,0,0,0,0,0,1,0,1,1, each level 16 cycles. `flag`=1 one edge after `load`, and `busy` falls 176 cycles after the transfer.
- Parity, 7E1: `char`=12'o0103 (data 1000011b) → bits 1,1,0,0,0,0,1, parity 1, one stop bit. Frame is 160 cycles.
- Back-to-back: `load` 12'o0101, then `load` 12'o0102 after `flag` rises → second start bit begins on the cycle after the first frame's last stop cycle. `flag` re-rises at that edge.
- Overrun and flag priority:
  - `load` with `hold` full → second character never appears on `tx`.
  - `set_flag` and `clear_flag` on the same edge → `flag`=1.
- `clear` mid-data-bit → `tx`=1 on the next edge, state IDLE. A following `load` produces a clean frame.
